// File: rtl/rv32_pkg.sv
// ---------------------------------------------------------------------------
// rv32_pkg -- constants and types shared by the RV32I pipeline stages.
//   XLEN             : architectural register / address width
//   NOP_INSN         : canonical NOP (addi x0, x0, 0) used for pipeline bubbles
//   DEFAULT_RESET_PC : byte address fetched first after reset
//   fetch_entry_t    : one fetched instruction word together with its PC
// ---------------------------------------------------------------------------
package rv32_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// if_fetch_stage_if -- signals between the fetch stage and its neighbours:
// the EX-stage redirect, the IF/ID register handshake and the synchronous
// instruction memory.
//   IF_ID_Stall  : IF/ID not accepting this cycle
//   PC_Redirect  : taken branch/jump resolved in EX
//   Redirect_PC  : redirect target byte address (bits [1:0] ignored)
//   imem_en      : instruction-memory read enable
//   imem_addr    : instruction-memory word address
//   imem_rdata   : read data, valid the cycle after imem_en
//   instOut / PC : instruction and its byte address presented to IF/ID
//   inst_valid   : instOut/PC carry a real fetched instruction
// master = fetch stage, slave = surrounding pipeline / memory.
// ---------------------------------------------------------------------------
interface if_fetch_stage_if #(
  parameter int IMEM_AW = 10
);
  logic               IF_ID_Stall;
  logic               PC_Redirect;
  logic [31:0]        Redirect_PC;
  logic               imem_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  logic [31:0]        instOut;
  logic [31:0]        PC;
  logic               inst_valid;

  modport master (
    input  IF_ID_Stall, PC_Redirect, Redirect_PC, imem_rdata,
    output imem_en, imem_addr, instOut, PC, inst_valid
  );

  modport slave (
    output IF_ID_Stall, PC_Redirect, Redirect_PC, imem_rdata,
    input  imem_en, imem_addr, instOut, PC, inst_valid
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// ---------------------------------------------------------------------------
// fetch_skid_buffer -- one-entry holding slot for a fetched word that IF/ID
// could not accept. Catches the memory response that would otherwise be lost
// because the synchronous memory does not hold its output.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture load_entry, mark valid
//   drain      : entry consumed downstream, mark empty
//   flush      : discard entry (redirect); wins over load and drain
//   entry      : held instruction + PC
//   valid      : entry holds a live instruction
// ---------------------------------------------------------------------------
module fetch_skid_buffer
  import rv32_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         drain,
  input  logic         flush,
  input  fetch_entry_t load_entry,
  output fetch_entry_t entry,
  output logic         valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  // NOTE: the payload has no reset; it is only ever read while valid is set,
  // so resetting it would add reset fan-out without changing behaviour.
  always_ff @(posedge clk) begin
    if (load) begin
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage -- RV32I instruction-fetch stage.
// Owns the fetch PC, issues one word read per cycle to a 1-cycle-latency
// instruction memory and presents instruction + PC to IF/ID. A one-entry
// skid buffer absorbs IF/ID stalls; an EX redirect squashes everything in
// flight and restarts fetch at the target.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : if_fetch_stage_if.master (redirect, IF/ID, imem signals)
// Parameters:
//   RESET_PC   : first byte address fetched after reset
//   IMEM_AW    : instruction-memory word-address width (must match bus)
// ---------------------------------------------------------------------------
module if_fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              IMEM_AW  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  if_fetch_stage_if.master      bus
);

  logic [XLEN-1:0] fetch_pc;    // next address to issue
  logic [XLEN-1:0] req_pc;      // address issued last cycle
  logic            req_valid;   // a memory response arrives this cycle

  fetch_entry_t    skid_entry;
  logic            skid_valid;

  logic            redirect;
  logic            issue;
  logic            skid_load;
  logic            skid_drain;
  logic            redirect_lsb_unused;

  assign redirect = bus.PC_Redirect;

  // Target is word aligned; the low two bits are dropped on purpose.
  assign redirect_lsb_unused = ^bus.Redirect_PC[1:0];

  // Output selection: the skid entry is always older than any response, so it
  // has priority. A redirect kills whatever is presented this cycle.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    bus.instOut    = NOP_INSN;
    bus.PC         = fetch_pc;
    bus.inst_valid = 1'b0;
    if (skid_valid) begin
      bus.instOut = skid_entry.inst;
      bus.PC      = skid_entry.pc;
    end else if (req_valid) begin
      bus.instOut = bus.imem_rdata;
      bus.PC      = req_pc;
    end
    if ((skid_valid || req_valid) && !redirect) begin
      bus.inst_valid = 1'b1;
    end else begin
      bus.instOut = NOP_INSN;
    end
  end

  // Issue whenever the presented slot will be free next cycle: either IF/ID
  // takes it now, or there is nothing valid in it.
  assign issue         = !redirect && (!bus.IF_ID_Stall || !bus.inst_valid);
  assign bus.imem_en   = issue;
  assign bus.imem_addr = fetch_pc[IMEM_AW+1:2];

  // A stalled live response must be caught now; the memory will not hold it.
  assign skid_load  = req_valid && bus.IF_ID_Stall && !skid_valid && !redirect;
  assign skid_drain = skid_valid && !bus.IF_ID_Stall;

  fetch_skid_buffer u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .drain      (skid_drain),
    .flush      (redirect),
    .load_entry ('{inst: bus.imem_rdata, pc: req_pc}),
    .entry      (skid_entry),
    .valid      (skid_valid)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc  <= RESET_PC;
      req_pc    <= RESET_PC;
      req_valid <= 1'b0;
    end else if (redirect) begin
      fetch_pc  <= {bus.Redirect_PC[XLEN-1:2], 2'b00};
      req_valid <= 1'b0;
    end else begin
      req_valid <= issue;
      if (issue) begin
        req_pc   <= fetch_pc;
        fetch_pc <= fetch_pc + 32'd4;   // wraps modulo 2^32
      end
    end
  end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage of the RV32I five-stage pipeline, directly upstream of the IF/ID pipeline register. Owns the fetch PC, issues word reads to a synchronous (1-cycle latency) instruction memory, and presents one instruction plus its PC per cycle to IF/ID. Absorbs IF/ID stalls with a one-entry skid buffer so no fetched word is lost, and squashes in-flight fetches on a branch/jump redirect from EX.

## Interface
- RESET_PC, 32'h0000_0000, first byte address fetched after reset
- IMEM_AW, 10, instruction-memory word-address width
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- IF_ID_Stall  in  1  IF/ID not accepting this cycle
- PC_Redirect  in  1  taken branch/jump resolved in EX
- Redirect_PC  in  32  redirect target byte address; bits [1:0] ignored
- imem_en  out  1  read enable to instruction memory
- imem_addr  out  IMEM_AW  word address, = issued PC[IMEM_AW+1:2]
- imem_rdata  in  32  read data; valid only in the cycle after an imem_en=1 cycle
- instOut  out  32  instruction to IF/ID; NOP 32'h00000013 when invalid
- PC  out  32  byte address of instOut
- inst_valid  out  1  instOut/PC hold a real fetched instruction

## Operation
- State: fetch_pc (next address to issue), req_pc/req_valid (read issued last cycle), skid_inst/skid_pc/skid_valid.
- Output mux (combinational): skid_valid → skid entry; else req_valid → imem_rdata, req_pc; else bubble (NOP, PC = fetch_pc, inst_valid=0).
- inst_valid = (skid_valid | req_valid) & !PC_Redirect.
- issue = !PC_Redirect & (!IF_ID_Stall | !inst_valid). On issue: imem_en=1, imem_addr from fetch_pc, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4. req_valid<=issue.
- Skid load: req_valid & IF_ID_Stall & !skid_valid & !PC_Redirect → skid<=(imem_rdata, req_pc), skid_valid<=1.
- Skid drain: skid_valid & !IF_ID_Stall → skid_valid<=0 (same cycle issues fetch_pc, no bubble).
- Invariant: skid_valid & req_valid never both 1.
- Redirect (highest priority, overrides stall): fetch_pc<={Redirect_PC[31:2],2'b00}; req_valid<=0; skid_valid<=0; imem_en=0.
- Arithmetic: fetch_pc+4 wraps modulo 2^32; imem_addr wraps at 4·2^IMEM_AW bytes.

## Timing
- Reset (async assert): fetch_pc=RESET_PC, req_valid=0, skid_valid=0; outputs imem_en=1 (issue, nothing valid), imem_addr=RESET_PC word, instOut=NOP, PC=RESET_PC, inst_valid=0.
- First edge after rst_n rise issues RESET_PC; its instruction is valid in the following cycle. Fetch latency: 1 cycle issue→present.
- Steady state with no stall: one valid instruction per cycle, PC increments by 4.
- Stall onset with req_valid: word goes to skid; no further issue until IF/ID accepts; stall release presents skid that cycle and issues next PC that cycle.
- Redirect in cycle N: outputs bubble in N; N+1 issues target, bubble; N+2 presents target instruction valid.
- Reset asserted mid-operation: all state returns to reset values immediately; in-flight response discarded.

## Structure
- Shared package rv32_pkg: NOP_INSN = 32'h00000013, XLEN = 32, default RESET_PC.
- One sub-module: fetch_skid_buffer (1-entry, data+PC, load/drain/flush).
- Single clock domain; no latches; imem model used by bench has 1-cycle read, no output hold.

## Test plan
- Reset release, mem[i]=32'h1000_0000+i, no stall → cycles 2..6 present PC 0,4,8,12,16 with matching words, inst_valid=1 throughout.
- Stall asserted 3 cycles while PC 8 is in flight → PC 8 held stable all 3 cycles, imem_en=0 during stall, PC 12 presented the cycle after release, no word lost or duplicated.
- PC_Redirect with Redirect_PC=32'h0000_0103 at PC 16 → two bubbles (NOP, inst_valid=0), then PC 32'h100 valid.
- PC_Redirect and IF_ID_Stall together while skid_valid=1 → skid discarded, stall ignored that cycle, target fetched next cycle.
- RESET_PC=32'hFFFF_FFF8, IMEM_AW=10 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr 1022, 1023, 0.
- rst_n pulsed low while skid_valid=1 → outputs immediately NOP/inst_valid=0/PC=RESET_PC; fetch restarts from RESET_PC.
